// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, synchronous-read instruction memory and a 2-entry prefetch queue.
// Define FETCH_MISALIGN_CHECK_EN to flag misaligned redirects and halt until an aligned one arrives.
module fetch_unit #(
    parameter int unsigned      IMEM_DEPTH = 1024,
    parameter int unsigned      PC_W       = 32,
    parameter logic [PC_W-1:0]  RESET_PC   = '0,
    parameter string            INIT_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    input  logic                          stall,
    input  logic                          im_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] im_waddr,
    input  logic [31:0]                   im_wdata,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst,
    output logic [PC_W-1:0]               inst_pc,
    output logic                          fetch_err
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0]     r_mem [IMEM_DEPTH];
    logic [31:0]     r_rdata;
    logic [PC_W-1:0] r_rd_pc;
    logic [PC_W-1:0] r_pc;
    logic            r_inflight;
    logic [1:0]      r_count;
    logic [31:0]     r_q_inst [2];
    logic [PC_W-1:0] r_q_pc   [2];

    logic            w_fire;
    logic            w_push;
    logic            w_issue;
    logic            w_halt;
    logic            w_slot;
    logic [1:0]      w_occ;
    logic [PC_W-1:0] w_redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_err;
    assign w_redirect_pc = redirect_pc;
    assign w_halt        = r_err;
    assign fetch_err     = r_err;
`else
    assign w_redirect_pc = redirect_pc & ~PC_W'(3);
    assign w_halt        = 1'b0;
    assign fetch_err     = 1'b0;
`endif

    assign w_fire  = (r_count != 2'd0) && inst_ready;
    assign w_push  = r_inflight && !redirect_valid;
    // Occupancy counts the slot freed by a pop this cycle, so a full queue can refill back-to-back.
    assign w_occ   = r_count - {1'b0, w_fire} + {1'b0, r_inflight};
    assign w_issue = !redirect_valid && !stall && !w_halt && (w_occ < 2'd2);
    assign w_slot  = (r_count - {1'b0, w_fire}) != 2'd0;

    assign inst_valid = (r_count != 2'd0);
    assign inst       = r_q_inst[0];
    assign inst_pc    = r_q_pc[0];

    // NOTE: the memory array and its read register carry no reset; clearing a RAM is not possible in one edge.
    always_ff @(posedge clk) begin
        if (im_we)
            r_mem[im_waddr] <= im_wdata;
        if (w_issue)
            r_rdata <= r_mem[r_pc[AW+1:2]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_rd_pc     <= '0;
            r_inflight  <= 1'b0;
            r_count     <= 2'd0;
            r_q_inst[0] <= '0;
            r_q_inst[1] <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else if (redirect_valid) begin
            r_pc       <= w_redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_err      <= (redirect_pc[1:0] != 2'b00);
`endif
        end else begin
            r_inflight <= w_issue;
            r_count    <= r_count - {1'b0, w_fire} + {1'b0, w_push};
            if (w_issue) begin
                r_pc    <= r_pc + PC_W'(4);
                r_rd_pc <= r_pc;
            end
            if (w_fire) begin
                r_q_inst[0] <= r_q_inst[1];
                r_q_pc[0]   <= r_q_pc[1];
            end
            // NOTE: with non-blocking assignments the later push into slot 0 overrides the shift above.
            if (w_push) begin
                if (w_slot) begin
                    r_q_inst[1] <= r_rdata;
                    r_q_pc[1]   <= r_rd_pc;
                end else begin
                    r_q_inst[0] <= r_rdata;
                    r_q_pc[0]   <= r_rd_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table vectors, corner-case sequences and a
// randomized run scored against an in-order PC-stream model.
module tb_fetch_unit;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        im_we = 1'b0;
    logic [9:0]  im_waddr = '0;
    logic [31:0] im_wdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    logic        w_im_we = 1'b0;
    logic [3:0]  w_im_waddr = '0;
    logic [31:0] w_im_wdata = '0;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_fetch_err;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] model_mem [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.IMEM_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .fetch_err(fetch_err)
    );

    // Small memory whose reset PC is the last word, so the second fetch wraps to word 0.
    fetch_unit #(.IMEM_DEPTH(16), .RESET_PC(32'd60)) u_wrap (
        .clk(clk), .rst_n(rst_n), .redirect_valid(1'b0), .redirect_pc(32'd0),
        .stall(1'b0), .im_we(w_im_we), .im_waddr(w_im_waddr), .im_wdata(w_im_wdata),
        .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst(w_inst), .inst_pc(w_inst_pc),
        .fetch_err(w_fetch_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n_sf;
        int          fires;
        logic [31:0] exp_pc;
        logic        prev_hold;
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        logic        redir;
        logic        rdy;
        logic [31:0] rp;

        tbl[0] = '{32'h2004001b, 32'h00}; tbl[1] = '{32'h38850005, 32'h04};
        tbl[2] = '{32'h00853020, 32'h08}; tbl[3] = '{32'h00a43822, 32'h0c};
        tbl[4] = '{32'h00e6402a, 32'h10}; tbl[5] = '{32'h00e04825, 32'h14};
        tbl[6] = '{32'h00e05024, 32'h18}; tbl[7] = '{32'h00075840, 32'h1c};
        tbl[8] = '{32'h00076042, 32'h20};

        // Preload both memories while reset is held.
        tick();
        for (int i = 0; i < 9; i++) begin
            im_we = 1'b1; im_waddr = 10'(i); im_wdata = tbl[i].word;
            w_im_we = (i < 2);
            w_im_waddr = (i == 0) ? 4'd15 : 4'd0;
            w_im_wdata = (i == 0) ? 32'hcafef00d : 32'h0badbeef;
            tick();
        end
        im_we = 1'b0; w_im_we = 1'b0;
        inst_ready = 1'b1;

        check("reset_valid", inst_valid, 1'b0);
        check("reset_inst", inst, 32'h0);
        check("reset_pc", inst_pc, 32'h0);
        check("reset_err", fetch_err, 1'b0);

        rst_n = 1'b1;
        tick();
        check("fill_e1_valid", inst_valid, 1'b0);
        tick();
        for (int i = 0; i < 9; i++) begin
            check("stream_valid", inst_valid, 1'b1);
            check("stream_inst", inst, tbl[i].word);
            check("stream_pc", inst_pc, tbl[i].pc);
            if (i == 0) begin
                check("wrap_first_pc", w_inst_pc, 32'd60);
                check("wrap_first_inst", w_inst, 32'hcafef00d);
            end
            if (i == 1) begin
                check("wrap_second_pc", w_inst_pc, 32'd64);
                check("wrap_second_inst", w_inst, 32'h0badbeef);
            end
            tick();
        end

        // Back-pressure: queue fills, head held stable, then drains in order.
        inst_ready = 1'b0;
        redirect_to(32'h0);
        check("bp_redir_valid", inst_valid, 1'b0);
        tick();
        check("bp_r1_valid", inst_valid, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", inst_valid, 1'b1);
            check("bp_hold_inst", inst, 32'h2004001b);
            check("bp_hold_pc", inst_pc, 32'h0);
            tick();
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_drain_valid", inst_valid, 1'b1);
            check("bp_drain_pc", inst_pc, tbl[k].pc);
            check("bp_drain_inst", inst, tbl[k].word);
            tick();
        end

        // Redirect with a full queue: nothing older survives.
        inst_ready = 1'b0;
        tick(); tick(); tick();
        redirect_to(32'h18);
        check("redir_r_valid", inst_valid, 1'b0);
        tick();
        check("redir_r1_valid", inst_valid, 1'b0);
        tick();
        inst_ready = 1'b1;
        for (int k = 6; k < 9; k++) begin
            check("redir_valid", inst_valid, 1'b1);
            check("redir_pc", inst_pc, tbl[k].pc);
            check("redir_inst", inst, tbl[k].word);
            tick();
        end

        // Stall: only the visible head and the in-flight read drain, then resume sequentially.
        redirect_to(32'h0);
        check("stall_redir_valid", inst_valid, 1'b0);
        tick(); tick();
        check("stall_pre_pc0", inst_pc, 32'h0);
        tick(); tick();
        check("stall_pre_pc8", inst_pc, 32'h8);
        stall = 1'b1;
        n_sf = 0;
        exp_pc = 32'h8;
        for (int c = 0; c < 5; c++) begin
            if (inst_valid) begin
                check("stall_fire_pc", inst_pc, exp_pc);
                exp_pc += 4;
                n_sf++;
            end
            tick();
        end
        check("stall_fires", n_sf, 2);
        check("stall_valid_drop", inst_valid, 1'b0);
        stall = 1'b0;
        for (int k = 0; k < 5 && !inst_valid; k++) tick();
        check("stall_resume_valid", inst_valid, 1'b1);
        check("stall_resume_pc", inst_pc, 32'h10);
        check("stall_resume_inst", inst, tbl[4].word);

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", inst_valid, 1'b0);
        check("async_rst_inst", inst, 32'h0);
        check("async_rst_pc", inst_pc, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_to(32'h6);
        check("misalign_err", fetch_err, 1'b1);
        check("misalign_valid", inst_valid, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("misalign_halt_valid", inst_valid, 1'b0);
        end
        redirect_to(32'h8);
        check("realign_err", fetch_err, 1'b0);
        tick(); tick();
        check("realign_valid", inst_valid, 1'b1);
        check("realign_pc", inst_pc, 32'h8);
        check("realign_inst", inst, 32'h00853020);
`else
        redirect_to(32'h6);
        check("misalign_err", fetch_err, 1'b0);
        tick(); tick();
        check("misalign_valid", inst_valid, 1'b1);
        check("misalign_pc", inst_pc, 32'h4);
        check("misalign_inst", inst, 32'h38850005);
`endif

        // Randomized run: every delivered word must follow the PC stream implied by the redirects.
        inst_ready = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = $urandom;
            im_we = 1'b1; im_waddr = 10'(i); im_wdata = model_mem[i];
            tick();
        end
        im_we = 1'b0;
        stall = 1'b0;
        exp_pc = '0;
        prev_hold = 1'b0;
        prev_inst = '0;
        prev_pc = '0;
        fires = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (prev_hold) begin
                check("rand_hold_valid", inst_valid, 1'b1);
                check("rand_hold_inst", inst, prev_inst);
                check("rand_hold_pc", inst_pc, prev_pc);
            end
            redir = (cyc == 0) || ($urandom_range(0, 15) == 0);
            rdy   = (cyc != 0) && ($urandom_range(0, 1) == 1);
            rp    = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            rp[1:0] = 2'b00;
`endif
            redirect_valid = redir;
            redirect_pc    = rp;
            inst_ready     = rdy;
            stall          = ($urandom_range(0, 3) == 0);
            if (inst_valid && rdy) begin
                check("rand_pc", inst_pc, exp_pc);
                check("rand_inst", inst, model_mem[exp_pc[11:2]]);
                exp_pc += 4;
                fires++;
            end
            if (redir) exp_pc = {rp[31:2], 2'b00};
            prev_hold = inst_valid && !rdy && !redir;
            prev_inst = inst;
            prev_pc   = inst_pc;
            tick();
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("rand_progress", fires > 200, 1'b1);
        check("rand_err", fetch_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
